muldiv_ctrl: RTL
================

// Module: muldiv_ctrl
// PURPOSE
//  Sequencer for the EX-stage HI/LO resource. Accepts MULT(U)/DIV(U)/MADD(U)/MSUB(U)/MTHI/MTLO,
//  runs an MUL_LAT-cycle multiplier or a 32-step iterative divider, and stalls EX via ready_o.
//  Holds the result until the EX stage advances, then issues exactly one HI/LO write.
//  Instantiated inside the EX stage; drives the hilo register file's we/wrdata.
// PARAMETERS
//  MUL_LAT   2   multiply sequencing cycles (>=1); retiming budget for the 32x32 product
// PORTS
//  clk            in   1        clock
//  rst            in   1        synchronous, active-high reset
//  flush_i        in   1        except_req.valid; aborts any operation
//  valid_i        in   1        EX instruction valid (pipe_id.valid)
//  op_i           in   oper_t   decoded op
//  reg0_i         in   32       rs operand
//  reg1_i         in   32       rt operand
//  hilo_i         in   64       current {HI,LO}
//  adv_i          in   1        EX stage registers this cycle (pipe_ex <= pipe_ex_n)
//  ready_o        out  1        0 = stall EX; 1 = result (if any) valid on hilo_o
//  hilo_we_o      out  1        HI/LO write strobe
//  hilo_o         out  64       {HI,LO} write data
//  busy_o         out  1        FSM not IDLE/DONE (perf counter, debug)
// BEHAVIOUR
//  - Reset/flush: state IDLE; ready_o=1, hilo_we_o=0, hilo_o=0, busy_o=0. Flush beats all.
//  - start = valid_i & op in {MULT*,DIV*,MADD*,MSUB*} & state==IDLE & ~flush_i. Latches
//    operands and hilo_i; ready_o=0 in the start cycle.
//  - States: IDLE -> MUL (MUL_LAT cycles) -> DONE; IDLE -> DIV (32 cycles) -> DONE.
//    DONE -> IDLE on adv_i. Start at cycle t: MUL done at t+MUL_LAT+1, DIV done at t+33.
//  - DONE: ready_o=1, hilo_o stable; hilo_we_o=adv_i & ~flush_i (one pulse, then IDLE).
//    DONE with adv_i=0 (other stall) holds the result and never restarts.
//  - MTHI/MTLO: no FSM; in IDLE ready_o=1, hilo_o={reg0,LO} / {HI,reg0}, hilo_we_o=valid_i&adv_i&~flush_i.
//  - Other ops or valid_i=0: ready_o=1, hilo_we_o=0.
//  - MULT/MADD/MSUB: signed 64b product; U variants unsigned. MADD: hilo+prod; MSUB: hilo-prod;
//    mod 2^64, no overflow trap.
//  - DIV: magnitudes to unsigned core; LO=quot, negated if sign0^sign1; HI=rem with dividend sign.
//    0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. Divide by zero: LO=0xFFFFFFFF, HI=reg0, no trap.
//  - flush_i mid MUL/DIV: IDLE next cycle, result discarded, no write.
// CONFIGURATION
//  MULDIV_DIV_EARLY_OUT_EN defined: DIV(U) with divisor 0 or |dividend|<|divisor| skips to DONE
//   at t+2 (HI=rem=dividend, LO=0 or div-by-zero value). Undefined: always the 32 DIV cycles.
//   Results are bit-identical either way; only latency differs.
// STRUCTURE
//  - cpu_defs package: muldiv_state_t {IDLE,MUL,DIV,DONE}; MULDIV_DIV_STEPS=32.
//    Existing oper_t is reused, not redefined.
//  - Sub-module div_iter_u32: unsigned radix-2 restoring divider.
//    start/done handshake, 1 quotient bit/cycle, 32 cycles.
//  - The multiplier is inline: a product register plus MUL_LAT-1 delay stages, retimable.
// TESTING
//  1 MULT 0xFFFFFFFE*3, MUL_LAT=2: ready_o low 3 cycles, hilo_o=0xFFFFFFFF_FFFFFFFA, 1 we pulse.
//  2 DIVU 100/7: ready_o rises t+33, hilo_o={2,14}; DIV 0xFFFFFF9C/7 -> {0xFFFFFFFE,0xFFFFFFF2}.
//  3 DIV 0x80000000/-1 -> {0,0x80000000}; DIVU 5/0 -> {5,0xFFFFFFFF}, no exception.
//  4 MADDU hilo=0xFFFFFFFF_FFFFFFFF, 1*1 -> hilo_o=0 (wrap); MSUB hilo=0, 2*3 -> 0xFFFFFFFF_FFFFFFFA.
//  5 flush_i at DIV cycle 10 -> IDLE, ready_o=1 next cycle, no hilo_we_o; next DIVU restarts clean.
//  6 DONE held with adv_i=0 for 5 cycles -> hilo_o constant, no we; adv_i=1 -> single we, back to IDLE.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU decode types plus the HI/LO sequencer state and divider step count.
// The operation enum is the one the decode stage already uses.
package cpu_defs;

    typedef enum logic [4:0] {
        OP_NOP,
        OP_ADD,
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU,
        OP_MADD,
        OP_MADDU,
        OP_MSUB,
        OP_MSUBU,
        OP_MTHI,
        OP_MTLO
    } oper_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } muldiv_state_t;

    localparam int MULDIV_DIV_STEPS = 32;

    function automatic logic is_mul_op(input oper_t op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic is_div_op(input oper_t op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_signed_op(input oper_t op);
        return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

endpackage

// File: rtl/div_iter_u32.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle.
// Latency: 32 cycles after start_i; done_o is high in the cycle whose edge retires the last step.
// Backpressure: none; results hold in quot_o/rem_o until the next start_i.
module div_iter_u32
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic        done_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    logic        busy_q;
    logic [4:0]  cnt_q;
    logic [31:0] quo_q, rem_q, dsr_q;
    logic [32:0] trial;
    logic        ge;

    assign trial = {rem_q, quo_q[31]};
    assign ge    = trial >= {1'b0, dsr_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            quo_q  <= dividend_i;
            rem_q  <= '0;
            dsr_q  <= divisor_i;
        end else if (busy_q) begin
            // trial < 2*divisor, so the difference always fits in 32 bits
            rem_q  <= ge ? (trial[31:0] - dsr_q) : trial[31:0];
            quo_q  <= {quo_q[30:0], ge};
            cnt_q  <= cnt_q + 5'd1;
            if (cnt_q == 5'(MULDIV_DIV_STEPS - 1))
                busy_q <= 1'b0;
        end
    end

    assign done_o = busy_q && (cnt_q == 5'(MULDIV_DIV_STEPS - 1));
    assign quot_o = quo_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage HI/LO sequencer: multiply/accumulate/divide/MTHI/MTLO with a single HI/LO write.
// Latency: MUL done at t+MUL_LAT+1, DIV at t+33 (t+2 on trivial divides with MULDIV_DIV_EARLY_OUT_EN).
// Backpressure: ready_o low stalls EX; in DONE the result is held until adv_i, then written once.
module muldiv_ctrl
    import cpu_defs::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        valid_i,
    input  oper_t       op_i,
    input  logic [31:0] reg0_i,
    input  logic [31:0] reg1_i,
    input  logic [63:0] hilo_i,
    input  logic        adv_i,
    output logic        ready_o,
    output logic        hilo_we_o,
    output logic [63:0] hilo_o,
    output logic        busy_o
);

    muldiv_state_t state_q, state_d;
    oper_t         op_q;
    logic [31:0]   a_q, b_q;
    logic [63:0]   hilo_q;
    logic [7:0]    cnt_q;
    logic          start;

    assign start = valid_i && (is_mul_op(op_i) || is_div_op(op_i)) && (state_q == IDLE) && !flush_i;

    always_ff @(posedge clk) begin
        if (start) begin
            op_q   <= op_i;
            a_q    <= reg0_i;
            b_q    <= reg1_i;
            hilo_q <= hilo_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start)
            cnt_q <= '0;
        else if (state_q == MUL)
            cnt_q <= cnt_q + 8'd1;
    end

    // Sign-extended 64x64 product truncated to 64 bits equals the signed 32x32 product mod 2^64.
    logic        msgn;
    logic [63:0] mul_a, mul_b, prod, mul_last_stage, mul_res;
    logic [63:0] mul_pipe [MUL_LAT];

    assign msgn  = is_signed_op(op_q);
    assign mul_a = {{32{msgn & a_q[31]}}, a_q};
    assign mul_b = {{32{msgn & b_q[31]}}, b_q};
    assign prod  = mul_a * mul_b;

    always_ff @(posedge clk) begin
        if (state_q == MUL) begin
            mul_pipe[0] <= prod;
            for (int i = 1; i < MUL_LAT; i++)
                mul_pipe[i] <= mul_pipe[i-1];
        end
    end

    assign mul_last_stage = mul_pipe[MUL_LAT-1];

    always_comb begin
        mul_res = mul_last_stage;
        if (op_q inside {OP_MADD, OP_MADDU})
            mul_res = hilo_q + mul_last_stage;
        else if (op_q inside {OP_MSUB, OP_MSUBU})
            mul_res = hilo_q - mul_last_stage;
    end

    logic        a_neg_i, b_neg_i, a_neg_q, b_neg_q;
    logic [31:0] mag_a_i, mag_b_i, div_q, div_r, quot_s, rem_s;
    logic        div_done, div_early;
    logic [63:0] div_res;

    assign a_neg_i = is_signed_op(op_i) & reg0_i[31];
    assign b_neg_i = is_signed_op(op_i) & reg1_i[31];
    assign mag_a_i = a_neg_i ? -reg0_i : reg0_i;
    assign mag_b_i = b_neg_i ? -reg1_i : reg1_i;

    div_iter_u32 u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start && is_div_op(op_i)),
        .dividend_i (mag_a_i),
        .divisor_i  (mag_b_i),
        .done_o     (div_done),
        .quot_o     (div_q),
        .rem_o      (div_r)
    );

`ifdef MULDIV_DIV_EARLY_OUT_EN
    logic early_q;
    always_ff @(posedge clk) begin
        if (rst)
            early_q <= 1'b0;
        else if (start)
            early_q <= is_div_op(op_i) && ((reg1_i == 32'd0) || (mag_a_i < mag_b_i));
    end
    assign div_early = early_q;
`else
    assign div_early = 1'b0;
`endif

    assign a_neg_q = is_signed_op(op_q) & a_q[31];
    assign b_neg_q = is_signed_op(op_q) & b_q[31];
    assign quot_s  = (a_neg_q ^ b_neg_q) ? -div_q : div_q;
    assign rem_s   = a_neg_q ? -div_r : div_r;

    // Zero divisor and |dividend|<|divisor| both leave the dividend as remainder
    always_comb begin
        div_res = {rem_s, quot_s};
        if (b_q == 32'd0)
            div_res = {a_q, 32'hFFFF_FFFF};
        else if (div_early)
            div_res = {a_q, 32'h0};
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = is_mul_op(op_i) ? MUL : DIV;
            MUL:  if (cnt_q == 8'(MUL_LAT - 1)) state_d = DONE;
            DIV:  if (div_done || div_early) state_d = DONE;
            DONE: if (adv_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i)
            state_d = IDLE;
    end

    always_comb begin
        ready_o   = 1'b1;
        hilo_we_o = 1'b0;
        hilo_o    = '0;
        busy_o    = 1'b0;
        if (!rst && !flush_i) begin
            case (state_q)
                IDLE: begin
                    if (start)
                        ready_o = 1'b0;
                    else if (valid_i && op_i == OP_MTHI) begin
                        hilo_o    = {reg0_i, hilo_i[31:0]};
                        hilo_we_o = adv_i;
                    end else if (valid_i && op_i == OP_MTLO) begin
                        hilo_o    = {hilo_i[63:32], reg0_i};
                        hilo_we_o = adv_i;
                    end
                end
                MUL, DIV: begin
                    ready_o = 1'b0;
                    busy_o  = 1'b1;
                end
                DONE: begin
                    hilo_o    = is_mul_op(op_q) ? mul_res : div_res;
                    hilo_we_o = adv_i;
                end
                default: ;
            endcase
        end
    end

endmodule
